// File: rtl/uart_rx_fifo.sv
// Receive buffer between the serial receiver and the Apple-1 UART registers.
// Stores 7-bit ASCII (optionally uppercased) and drives CTS with hysteresis.
module uart_rx_fifo #(
    parameter int Depth      = 16,
    parameter int AddrW      = 4,
    parameter int HighWater  = 12,
    parameter int LowWater   = 4,
    parameter int ForceUpper = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_stb,
    input  logic [7:0]       rx_data,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             valid,
    output logic [AddrW:0]   count,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             uart_cts
);

    localparam logic [AddrW:0] DEPTH_C = (AddrW+1)'(Depth);
    localparam logic [AddrW:0] HIGH_C  = (AddrW+1)'(HighWater);
    localparam logic [AddrW:0] LOW_C   = (AddrW+1)'(LowWater);

    logic [6:0]       r_mem [Depth];
    logic [AddrW-1:0] r_wptr;
    logic [AddrW-1:0] r_rptr;
    logic [AddrW:0]   r_count;
    logic             r_overflow;
    logic             r_cts;

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_drop;
    logic [6:0]       w_wdata;
    logic [AddrW:0]   w_count_nxt;
    logic             w_cts_nxt;

    // Handshake: valid=1 means dout holds the head byte; a pop while valid=1
    // consumes it on that edge, a pop while valid=0 is ignored. rx_stb is
    // accepted unless the FIFO is full and no pop frees a slot that cycle.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = rx_stb && (!w_full || w_do_pop);
    assign w_drop    = rx_stb && !w_do_push;

    always_comb begin
        w_wdata = rx_data[6:0];
        if ((ForceUpper != 0) && (rx_data[6:0] >= 7'h61) && (rx_data[6:0] <= 7'h7A)) begin
            w_wdata = rx_data[6:0] - 7'h20;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + (AddrW+1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - (AddrW+1)'(1);
        end
    end

    // CTS only changes when the new occupancy crosses the opposite threshold.
    always_comb begin
        w_cts_nxt = r_cts;
        if (!r_cts && (w_count_nxt >= HIGH_C)) begin
            w_cts_nxt = 1'b1;
        end else if (r_cts && (w_count_nxt <= LOW_C)) begin
            w_cts_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cts      <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AddrW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AddrW'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            r_cts <= w_cts_nxt;
        end
    end

    // Storage content needs no reset: it is unreachable while count is zero.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    assign valid    = !w_empty;
    assign dout     = w_empty ? 8'h00 : {1'b0, r_mem[r_rptr]};
    assign count    = r_count;
    assign overflow = r_overflow;
    assign uart_cts = r_cts;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx_stb;
    logic [7:0] rx_data;
    logic       pop;
    logic       overflow_clr;
    logic [7:0] dout;
    logic       valid;
    logic [4:0] count;
    logic       overflow;
    logic       uart_cts;
    logic [7:0] dout_nu;
    logic       valid_nu;
    logic [4:0] count_nu;
    logic       overflow_nu;
    logic       uart_cts_nu;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state.
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_cts = 1'b0;

    uart_rx_fifo #(.Depth(16), .AddrW(4), .HighWater(12), .LowWater(4), .ForceUpper(1)) dut (
        .clk(clk), .reset(reset), .rx_stb(rx_stb), .rx_data(rx_data), .pop(pop),
        .dout(dout), .valid(valid), .count(count), .overflow(overflow),
        .overflow_clr(overflow_clr), .uart_cts(uart_cts)
    );

    uart_rx_fifo #(.Depth(16), .AddrW(4), .HighWater(12), .LowWater(4), .ForceUpper(0)) dut_nu (
        .clk(clk), .reset(reset), .rx_stb(rx_stb), .rx_data(rx_data), .pop(pop),
        .dout(dout_nu), .valid(valid_nu), .count(count_nu), .overflow(overflow_nu),
        .overflow_clr(overflow_clr), .uart_cts(uart_cts_nu)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xform(input logic [7:0] b);
        logic [7:0] v;
        v = {1'b0, b[6:0]};
        if (v >= 8'h61 && v <= 8'h7A) v = v - 8'h20;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of bytes, updated on the same edge the DUT samples.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_cts = 1'b0;
        end else begin
            bit did_pop;
            bit dropped;
            did_pop = pop && (exp_q.size() > 0);
            dropped = rx_stb && (exp_q.size() == 16) && !did_pop;
            if (did_pop) void'(exp_q.pop_front());
            if (rx_stb && !dropped) exp_q.push_back(xform(rx_data));
            if (dropped) exp_ovf = 1'b1;
            else if (overflow_clr) exp_ovf = 1'b0;
            if (!exp_cts && exp_q.size() >= 12) exp_cts = 1'b1;
            else if (exp_cts && exp_q.size() <= 4) exp_cts = 1'b0;
        end
    end

    // Compare process: outputs depend only on registered state, so sample at negedge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_dout", dout, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
            check("m_valid", valid, exp_q.size() > 0);
            check("m_count", count, exp_q.size());
            check("m_overflow", overflow, exp_ovf);
            check("m_cts", uart_cts, exp_cts);
        end
    end

    // Driver: inputs are applied just after a negedge, held over one posedge,
    // and the task returns at the next negedge with inputs idle again.
    task automatic drive(input logic stb, input logic [7:0] d, input logic p,
                         input logic clr, input logic rst);
        rx_stb = stb; rx_data = d; pop = p; overflow_clr = clr; reset = rst;
        @(negedge clk);
        rx_stb = 1'b0; rx_data = 8'h00; pop = 1'b0; overflow_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rx_stb = 1'b0; rx_data = 8'h00; pop = 1'b0; overflow_clr = 1'b0; reset = 1'b1;
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_cts", uart_cts, 0);

        // Lowercase mapping, and the ForceUpper=0 instance keeping it.
        push(8'h61);
        check("lc_dout", dout, 8'h41);
        check("lc_valid", valid, 1);
        check("lc_count", count, 1);
        check("nu_dout", dout_nu, 8'h61);
        pop_one();
        check("pop_valid", valid, 0);
        check("pop_dout", dout, 8'h00);
        check("pop_count", count, 0);
        pop_one();
        check("pop_empty_count", count, 0);

        // Bit 7 cleared, 0x7B kept, uppercase kept.
        push(8'hC1); push(8'h7B); push(8'h5A);
        check("xf0", dout, 8'h41); pop_one();
        check("xf1", dout, 8'h7B); pop_one();
        check("xf2", dout, 8'h5A); pop_one();
        check("xf_empty", valid, 0);

        // Fill, overflow drop, drain, clear.
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        check("full_count", count, 16);
        push(8'h40);
        check("drop_ovf", overflow, 1);
        check("drop_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            check("drain", dout, 8'h30 + 8'(i));
            pop_one();
        end
        check("drain_empty", valid, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_clr", overflow, 0);

        // Simultaneous push and pop when full, then when empty.
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("fullpp_count", count, 16);
        check("fullpp_ovf", overflow, 0);
        for (int i = 0; i < 15; i++) begin
            check("fullpp_drain", dout, 8'h11 + 8'(i));
            pop_one();
        end
        check("fullpp_last", dout, 8'h55);
        pop_one();
        drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        check("emptypp_count", count, 1);
        check("emptypp_dout", dout, 8'h22);
        pop_one();

        // CTS hysteresis.
        for (int i = 0; i < 11; i++) push(8'h20 + 8'(i));
        check("cts_11", uart_cts, 0);
        push(8'h2B);
        check("cts_12", uart_cts, 1);
        for (int i = 0; i < 7; i++) pop_one();
        check("cts_5_count", count, 5);
        check("cts_5", uart_cts, 1);
        pop_one();
        check("cts_4", uart_cts, 0);
        push(8'h2C);
        check("cts_back5", uart_cts, 0);

        // Reset mid-operation with data, overflow and CTS all set.
        for (int i = 0; i < 11; i++) push(8'h40 + 8'(i));
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check("setwins_ovf", overflow, 1);
        for (int i = 0; i < 9; i++) pop_one();
        check("pre_rst_count", count, 7);
        check("pre_rst_cts", uart_cts, 1);
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        check("mrst_count", count, 0);
        check("mrst_valid", valid, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_cts", uart_cts, 0);

        // Pointer wrap-around.
        for (int i = 0; i < 40; i++) begin
            push(8'h20 + 8'(i));
            check("wrap_data", dout, 8'h20 + 8'(i));
            pop_one();
            check("wrap_empty", valid, 0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the async serial receiver and the Apple-1 UART register interface (0xD010/0xD011). Absorbs bursts of received bytes, such as pasted programs, that the CPU cannot poll fast enough. Normalises each byte to 7-bit uppercase ASCII. Drives CTS with hysteresis so the host pauses before the buffer overflows.

Parameters:
Depth, 16, number of entries; power of two, minimum 4
AddrW, 4, log2(Depth)
HighWater, 12, occupancy at which CTS asserts (stop sending)
LowWater, 4, occupancy at which CTS deasserts; must be less than HighWater
ForceUpper, 1, 1 = map 'a'..'z' (0x61..0x7A) to 'A'..'Z' on write

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_stb  input  1  one-cycle strobe: rx_data holds a new received byte
rx_data  input  8  received byte
pop  input  1  one-cycle CPU read acknowledge (read of 0xD010)
dout  output  8  head entry, first-word fall-through: {1'b0, data[6:0]}
valid  output  1  FIFO non-empty; drives RXCR bit 7
count  output  AddrW+1  current occupancy, 0..Depth
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full
overflow_clr  input  1  one-cycle clear of overflow
uart_cts  output  1  1 = host must stop sending

Behaviour:
- Reset (synchronous, on the clk edge while reset=1), applied mid-operation as well:
  - read and write pointers := 0, count := 0, valid := 0, dout := 0x00, overflow := 0, uart_cts := 0.
  - Buffered content is discarded.
  - An rx_stb or pop in the reset cycle is ignored.
- Write transform, applied before storage:
  - bit 7 forced to 0.
  - If ForceUpper=1 and the 7-bit value is in 0x61..0x7A, subtract 0x20.
  - All other values are stored unchanged (0x7B..0x7F included).
- Push: rx_stb=1 and count<Depth → store at wptr; wptr wraps modulo Depth; count+1.
- Push when full: rx_stb=1, count=Depth, pop=0 → byte dropped, overflow := 1, FIFO unchanged.
- Pop: pop=1 and count>0 → rptr wraps modulo Depth; count-1.
- Pop when empty: ignored; no pointer or count change, no error.
- Simultaneous rx_stb and pop:
  - count>0: both happen, count unchanged.
  - Full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Empty: the pop is ignored and the push is accepted; count becomes 1.
- Fall-through: dout/valid always reflect the entry at rptr and update in the cycle after the push or pop edge.
  - Push to an empty FIFO: valid=1 and dout = transformed byte one cycle after the rx_stb edge.
  - When empty, dout = 0x00.
- overflow:
  - Sticky until overflow_clr=1.
  - If overflow_clr and a dropping push occur in the same cycle, set wins (overflow stays 1).
- uart_cts is registered, with hysteresis:
  - 0→1 when the next-state count ≥ HighWater.
  - 1→0 when the next-state count ≤ LowWater.
  - Otherwise it holds.
- Storage: a register array or inferred RAM with combinational read of the head. No read latency is visible at dout.

Test Plan:
- Reset, then one rx_stb with 0x61 → next cycle valid=1, dout=0x41, count=1. Pop → next cycle valid=0, dout=0x00, count=0.
- Push 0xC1, then 0x7B, then 0x5A → popped in order as 0x41, 0x7B, 0x5A. Repeat with ForceUpper=0 and push 0x61 → dout=0x61.
- Push 16 bytes 0x30..0x3F → count=16. Push a 17th byte 0x40 → dropped, overflow=1, count=16. Pop 16 times → data 0x30..0x3F in order, no 0x40. Pulse overflow_clr → overflow=0.
- With the FIFO full, assert rx_stb(0x55) and pop in the same cycle → count stays 16, overflow stays 0, 0x55 is the last byte popped. With the FIFO empty, assert rx_stb(0x22) and pop together → count=1, dout=0x22.
- CTS hysteresis:
  - Push to 11 entries → uart_cts=0; push the 12th → uart_cts=1.
  - Pop down to 5 entries → uart_cts stays 1; pop to 4 → uart_cts=0.
  - Push back to 5 → uart_cts stays 0.
- Reset with 7 entries buffered, overflow=1 and uart_cts=1 → after the reset edge count=0, valid=0, overflow=0, uart_cts=0. Wrap-around: 40 push/pop pairs with incrementing data → every popped byte equals the pushed byte.
